// File: rtl/dep_matrix_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dep_matrix_issue_pkg
// Purpose  : Shared definitions for the dependency-matrix scheduler and the
//            upstream register-dependency tracker: default buffer depth,
//            derived slot index width, slot index type, output FSM state
//            encodings and a one-hot helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dep_matrix_issue_pkg;

    localparam int c_BS = 16;
    localparam int c_IW = $clog2(c_BS);

    typedef logic [c_IW-1:0] slot_idx_t;

    // Output FSM: IDLE has nothing presented, HOLD presents issue_index.
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_HOLD = 1'b1;

    function automatic logic [c_BS-1:0] onehot(input slot_idx_t idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dep_matrix_issue_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Purpose  : Round-robin selector. Returns the first set request bit found
//            searching upward from i_ptr, wrapping at N.
// Ports    : i_req   - N-bit request vector
//            i_ptr   - search start index
//            o_grant - index of the selected request
//            o_found - at least one request is set
// Revision : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int N  = 16,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_grant,
    output logic          o_found
);

    logic [N-1:0]  w_rot;
    logic [IW-1:0] w_off;

    // Rotate so that bit 0 corresponds to i_ptr; IW-bit index arithmetic
    // wraps naturally because N is a power of two.
    always_comb begin
        w_rot = '0;
        for (int k = 0; k < N; k++) begin
            w_rot[k] = i_req[i_ptr + IW'(k)];
        end
    end

    // Lowest set bit of the rotated vector wins (scan down, last hit sticks).
    always_comb begin
        w_off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IW'(k);
            end
        end
    end

    assign o_found = |i_req;
    assign o_grant = i_ptr + w_off;

endmodule
`default_nettype wire

// File: rtl/dep_matrix_issue.sv
`default_nettype none
// ============================================================================
// Module   : dep_matrix_issue
// Purpose  : BS x BS wait-matrix scheduler. Each buffer slot holds a row of
//            slots it waits on; completions clear columns, and slots with an
//            empty row are issued round-robin through a registered
//            valid/ready output.
// Ports    : clk, rst              - clock, async active-high reset
//            wr_valid/index/dep    - install a dependency row
//            cpl_valid/index       - slot completion strobe
//            issue_ready           - execute stage accepts
//            issue_valid/index     - slot presented for issue
//            ready_vec             - valid, unissued, dependency-free slots
//            occupancy             - number of valid slots
//            err_overwrite/err_cpl - one-cycle error pulses
//            stat_issued/stat_stall (only with DEP_MATRIX_STATS_EN defined)
// Options  : DEP_MATRIX_STATS_EN adds accepted-issue and stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module dep_matrix_issue
    import dep_matrix_issue_pkg::*;
#(
    parameter int BS = c_BS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    input  logic [$clog2(BS)-1:0]    wr_index,
    input  logic [BS-1:0]            wr_dep,
    input  logic                     cpl_valid,
    input  logic [$clog2(BS)-1:0]    cpl_index,
    input  logic                     issue_ready,
    output logic                     issue_valid,
    output logic [$clog2(BS)-1:0]    issue_index,
    output logic [BS-1:0]            ready_vec,
    output logic [$clog2(BS):0]      occupancy,
    output logic                     err_overwrite,
    output logic                     err_cpl
`ifdef DEP_MATRIX_STATS_EN
    ,
    output logic [31:0]              stat_issued,
    output logic [31:0]              stat_stall
`endif
);

    localparam int IW = $clog2(BS);
    localparam logic [BS-1:0] c_ONE = BS'(1);

    logic [BS-1:0] r_valid;
    logic [BS-1:0] r_issued;
    logic [BS-1:0] r_dep [BS];
    logic [IW-1:0] r_ptr;
    logic [IW:0]   r_occ;
    logic [0:0]    r_state;

    logic [0:0]    w_state_nxt;
    logic          w_load;
    logic          w_cpl_ok;
    logic [BS-1:0] w_cpl_mask;
    logic [BS-1:0] w_wr_mask;
    logic [BS-1:0] w_acc_mask;
    logic [BS-1:0] w_valid_after_cpl;
    logic          w_wr_new;
    logic          w_accept;
    logic [BS-1:0] w_cand;
    logic [IW-1:0] w_pick_ptr;
    logic [IW-1:0] w_grant;
    logic          w_found;

    // ---------------------------------------------------------------------
    // Completion, write and accept decode
    // ---------------------------------------------------------------------
    assign w_cpl_ok          = cpl_valid & r_valid[cpl_index] & r_issued[cpl_index];
    assign w_cpl_mask        = w_cpl_ok ? (c_ONE << cpl_index) : '0;
    assign w_wr_mask         = wr_valid ? (c_ONE << wr_index) : '0;
    assign w_valid_after_cpl = r_valid & ~w_cpl_mask;
    // A slot freed by a same-index completion counts as empty for the write.
    assign w_wr_new          = wr_valid & ~w_valid_after_cpl[wr_index];
    assign w_accept          = issue_valid & issue_ready;
    assign w_acc_mask        = w_accept ? (c_ONE << issue_index) : '0;

    // ---------------------------------------------------------------------
    // Per-slot state
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= '0;
            r_issued <= '0;
        end else begin
            r_valid  <= w_valid_after_cpl | w_wr_mask;
            // A fresh install always starts unissued, even over an accept.
            r_issued <= ((r_issued & ~w_cpl_mask) | w_acc_mask) & ~w_wr_mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < BS; r++) begin
                r_dep[r] <= '0;
            end
        end else begin
            for (int r = 0; r < BS; r++) begin
                if (wr_valid && (wr_index == IW'(r))) begin
                    // Drop waits on empty/completing slots and on itself.
                    r_dep[r] <= wr_dep & w_valid_after_cpl & ~w_wr_mask;
                end else begin
                    r_dep[r] <= r_dep[r] & ~w_cpl_mask;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ         <= '0;
            err_overwrite <= 1'b0;
            err_cpl       <= 1'b0;
        end else begin
            r_occ         <= r_occ + {{IW{1'b0}}, w_wr_new} - {{IW{1'b0}}, w_cpl_ok};
            err_overwrite <= wr_valid & w_valid_after_cpl[wr_index];
            err_cpl       <= cpl_valid & ~w_cpl_ok;
        end
    end

    assign occupancy = r_occ;

    generate
        for (genvar i = 0; i < BS; i++) begin : g_ready
            assign ready_vec[i] = r_valid[i] & ~r_issued[i] & ~(|r_dep[i]);
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Round-robin pick. On an accept the search starts just past the
    // accepted slot and that slot is excluded, since its issued bit only
    // lands at this edge.
    // ---------------------------------------------------------------------
    assign w_cand     = ready_vec & ~w_acc_mask;
    assign w_pick_ptr = w_accept ? (issue_index + IW'(1)) : r_ptr;

    rr_picker #(
        .N  (BS),
        .IW (IW)
    ) u_rr_picker (
        .i_req   (w_cand),
        .i_ptr   (w_pick_ptr),
        .o_grant (w_grant),
        .o_found (w_found)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= issue_index + IW'(1);
        end
    end

    // ---------------------------------------------------------------------
    // Output FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = c_ST_HOLD;
                    w_load      = 1'b1;
                end
            end
            c_ST_HOLD: begin
                if (issue_ready) begin
                    w_state_nxt = w_found ? c_ST_HOLD : c_ST_IDLE;
                    w_load      = w_found;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_comb begin
        issue_valid = (r_state == c_ST_HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_index <= '0;
        end else if (w_load) begin
            issue_index <= w_grant;
        end
    end

`ifdef DEP_MATRIX_STATS_EN
    // ---------------------------------------------------------------------
    // Statistics counters (wrap on overflow)
    // ---------------------------------------------------------------------
    logic [31:0] r_stat_issued;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_issued <= '0;
            r_stat_stall  <= '0;
        end else begin
            if (w_accept) begin
                r_stat_issued <= r_stat_issued + 32'd1;
            end
            if (issue_valid && !issue_ready) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_issued = r_stat_issued;
    assign stat_stall  = r_stat_stall;
`endif

endmodule
`default_nettype wire
